// File: rtl/muldiv_hilo_unit_if.sv
// Issue/result bundle between the ALU decoder side and the HI/LO multiply/divide unit.
interface muldiv_hilo_unit_if;
    logic        start;
    logic [4:0]  alu_control;
    logic        LO_write_enable;
    logic        HI_write_enable;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, alu_control, LO_write_enable, HI_write_enable, op_a, op_b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, alu_control, LO_write_enable, HI_write_enable, op_a, op_b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit owning HI and LO.
// One shared 64-bit accumulator serves both the shift-add multiplier and the restoring divider.
module muldiv_hilo_unit (
    input  logic               clk,
    input  logic               reset_n,
    muldiv_hilo_unit_if.slave  bus
);
    localparam logic [4:0] OP_MULT  = 5'b10000;
    localparam logic [4:0] OP_MULTU = 5'b10001;
    localparam logic [4:0] OP_DIV   = 5'b10010;
    localparam logic [4:0] OP_DIVU  = 5'b10011;
    localparam logic [4:0] OP_MTLO  = 5'b10101;
    localparam logic [4:0] OP_MTHI  = 5'b10110;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state_reg;
    logic [4:0]  cnt_reg;
    logic [63:0] acc_reg;
    logic [31:0] b_reg;
    logic        is_div_reg;
    logic        neg_res_reg;
    logic        neg_rem_reg;
    logic        dbz_reg;
    logic        hi_en_reg;
    logic        lo_en_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    logic        is_mul_op;
    logic        is_div_op;
    logic        is_signed_op;
    logic        idle_start;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    always_comb begin
        is_mul_op    = (bus.alu_control == OP_MULT) || (bus.alu_control == OP_MULTU);
        is_div_op    = (bus.alu_control == OP_DIV)  || (bus.alu_control == OP_DIVU);
        is_signed_op = (bus.alu_control == OP_MULT) || (bus.alu_control == OP_DIV);
        idle_start   = bus.start && (state_reg == IDLE);
        a_neg        = is_signed_op && bus.op_a[31];
        b_neg        = is_signed_op && bus.op_b[31];
        a_mag        = a_neg ? -bus.op_a : bus.op_a;
        b_mag        = b_neg ? -bus.op_b : bus.op_b;
    end

    // Multiply: acc = {partial product, remaining multiplier bits}, b_reg = multiplicand.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    // Divide: acc = {remainder, remaining dividend bits / quotient bits}, b_reg = divisor.
    logic [32:0] div_shift;
    logic [33:0] div_trial;
    logic        div_fit;
    logic [31:0] div_rem;
    logic [63:0] div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, b_reg} : 33'd0);
        mul_next  = {mul_sum, acc_reg[31:1]};
        div_shift = {acc_reg[63:32], acc_reg[31]};
        div_trial = {1'b0, div_shift} - {2'b00, b_reg};
        div_fit   = !div_trial[33];
        div_rem   = div_fit ? div_trial[31:0] : div_shift[31:0];
        div_next  = {div_rem, acc_reg[30:0], div_fit};
    end

    logic [63:0] prod_signed;
    logic [31:0] quo_signed;
    logic [31:0] rem_signed;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;

    // With a zero divisor every trial subtract fits, so the remainder ends up as |op_a|;
    // restoring the dividend's sign reproduces op_a exactly for HI.
    always_comb begin
        prod_signed = neg_res_reg ? -acc_reg : acc_reg;
        quo_signed  = neg_res_reg ? -acc_reg[31:0] : acc_reg[31:0];
        rem_signed  = neg_rem_reg ? -acc_reg[63:32] : acc_reg[63:32];
        if (is_div_reg) begin
            fix_hi = rem_signed;
            fix_lo = dbz_reg ? 32'hFFFF_FFFF : quo_signed;
        end else begin
            fix_hi = prod_signed[63:32];
            fix_lo = prod_signed[31:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= 5'd0;
            acc_reg     <= 64'd0;
            b_reg       <= 32'd0;
            is_div_reg  <= 1'b0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            dbz_reg     <= 1'b0;
            hi_en_reg   <= 1'b0;
            lo_en_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (idle_start) begin
                        if ((bus.alu_control == OP_MTHI) && bus.HI_write_enable)
                            hi_reg <= bus.op_a;
                        if ((bus.alu_control == OP_MTLO) && bus.LO_write_enable)
                            lo_reg <= bus.op_a;
                        if (is_mul_op || is_div_op) begin
                            state_reg   <= RUN;
                            busy_reg    <= 1'b1;
                            cnt_reg     <= 5'd0;
                            is_div_reg  <= is_div_op;
                            neg_res_reg <= a_neg ^ b_neg;
                            neg_rem_reg <= a_neg;
                            dbz_reg     <= is_div_op && (bus.op_b == 32'd0);
                            hi_en_reg   <= bus.HI_write_enable;
                            lo_en_reg   <= bus.LO_write_enable;
                            acc_reg     <= {32'd0, is_div_op ? a_mag : b_mag};
                            b_reg       <= is_div_op ? b_mag : a_mag;
                        end
                    end
                end
                RUN: begin
                    acc_reg <= is_div_reg ? div_next : mul_next;
                    cnt_reg <= cnt_reg + 5'd1;
                    if (cnt_reg == 5'd31)
                        state_reg <= FIX;
                end
                FIX: begin
                    if (hi_en_reg)
                        hi_reg <= fix_hi;
                    if (lo_en_reg)
                        lo_reg <= fix_lo;
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;
endmodule

// File: doc/muldiv_hilo_unit.md
# muldiv_hilo_unit

Multi-cycle multiply/divide execution unit that owns the architectural HI and LO registers. It sits directly downstream of the ALU decoder. It consumes the decoder's `alu_control`, `LO_write_enable` and `HI_write_enable` together with the rs/rt operand values, and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It holds `busy` so the pipeline controller stalls while an iterative operation is in flight.

## Interface
- No parameters. Width is fixed at 32-bit operands and 64-bit HI:LO.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low. All state and outputs clear immediately on assertion.
- `start`  in  1  issue strobe; the operation is valid this cycle.
- `alu_control`  in  5  decoded operation: MULT=10000, MULTU=10001, DIV=10010, DIVU=10011, MTLO=10101, MTHI=10110. All other codes are ignored.
- `LO_write_enable`  in  1  decoder enable for LO.
- `HI_write_enable`  in  1  decoder enable for HI.
- `op_a`  in  32  rs value: multiplicand, dividend, or MTHI/MTLO source.
- `op_b`  in  32  rt value: multiplier or divisor.
- `busy`  out  1  high while an iterative operation is in flight.
- `done`  out  1  one-cycle pulse in the first cycle that new HI/LO from MULT/DIV are visible.
- `hi`  out  32  architectural HI register.
- `lo`  out  32  architectural LO register.

## Operation
- **Acceptance.** An operation is accepted on a rising edge where `start`=1, `busy`=0, and `alu_control` is one of the six listed codes.
  - `start` while `busy`=1 is ignored; upstream must hold the instruction.
  - Unlisted codes are ignored.
- **Enable capture.** The enables are latched at acceptance. The final HI/LO write honours the latched enables only; a cleared enable suppresses that register's write.
- **MTHI/MTLO.**
  - Single cycle, no `busy`, no `done`.
  - MTHI writes `hi`←`op_a` at the acceptance edge if `HI_write_enable`=1.
  - MTLO writes `lo`←`op_a` at the acceptance edge if `LO_write_enable`=1.
- **State machine:** IDLE, RUN, FIX.
  - IDLE → RUN on acceptance of MULT/MULTU/DIV/DIVU. Operands are latched. For the signed ops, magnitudes are latched and the sign flags are recorded. The 5-bit iteration counter is cleared.
  - RUN performs one iteration per edge. The counter increments and wraps 31→0 on the edge that moves to FIX. RUN lasts exactly 32 edges.
  - FIX applies sign correction, writes `hi`/`lo` per the latched enables, and returns to IDLE.
- **Multiply.** Radix-2 shift-add over a 64-bit accumulator of unsigned magnitudes. MULT negates the 64-bit product when the operand signs differ.
- **Divide.** Restoring division, one quotient bit per iteration, using a 33-bit partial remainder.
  - LO = quotient, HI = remainder.
  - For DIV, the quotient is negated when the signs differ, and the remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (falls out of the magnitude algorithm).
- **Divide by zero (DIV or DIVU).** LO=0xFFFFFFFF and HI=`op_a` unmodified. Latency is unchanged (full 32+1 edges) with no early exit.
- **No forwarding.** `hi`/`lo` hold their old values throughout RUN; MFHI/MFLO issued during `busy` read stale values and must be stalled by the controller.

## Timing
- **Reset values:** `hi`=0, `lo`=0, `busy`=0, `done`=0, state=IDLE, counter=0.
- **Reset mid-operation** aborts the operation: HI/LO return to 0 and no `done` is produced.
- **MULT/DIV latency.** With the acceptance edge as E0:
  - `busy`=1 in the cycles after E0 through E32.
  - E1..E32 are the iterations.
  - E33 is the FIX write.
  - `hi`/`lo` show the result and `done`=1 in the cycle after E33.
  - `busy`=0 in that same cycle, so a new `start` is accepted at E34 (back-to-back issue).
- **`done`** is registered, exactly one cycle wide, and never asserted for MTHI/MTLO.
- **MTHI/MTLO** results are visible in the cycle after acceptance.
- **`start` held high** across several cycles: one operation is accepted at E0. Re-acceptance occurs only at the first edge with `busy`=0.

## Test plan
- **MULTU, full-scale operands.** MULTU `op_a`=0xFFFFFFFF, `op_b`=0xFFFFFFFF → after 33 edges `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` pulses once, `busy` high for exactly 33 cycles.
- **MULT, mixed signs.** MULT -3 (0xFFFFFFFD) × 5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- **DIV, negative dividend.** DIV -7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **DIVU by zero.** DIVU 0x64 / 0 → `lo`=0xFFFFFFFF, `hi`=0x00000064, standard latency.
- **Single-cycle writes and stall behaviour.** MTLO 0x12345678 → `lo` updates next cycle, `busy`/`done` stay 0. Then start MULTU 2×3 and pulse MTHI 0xDEAD during `busy` → MTHI ignored, final `hi`=0, `lo`=6.
- **Reset mid-operation.** Start DIVU 100/7 and assert `reset_n`=0 at RUN iteration 10 → `hi`=`lo`=0, `busy`=0 immediately, and no `done` after reset release.
